// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO of ALU results with status flags,
// sticky overflow and saturating drop counter.
module alu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_result,
  input  logic                     in_zero,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_result,
  output logic                     out_zero,
  output logic                     out_cout,
  output logic                     out_overflow,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  input  logic                     ovf_clear,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic        zero;
    logic [31:0] result;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        wdata;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

  assign wdata = '{ovf:    in_overflow,
                   cout:   in_cout,
                   zero:   in_zero,
                   result: in_result};

  assign head         = mem[rd_ptr];
  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_cout     = head.cout;
  assign out_overflow = head.ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push && in_overflow) ovf_sticky <= 1'b1;
      else if (ovf_clear)      ovf_sticky <= 1'b0;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed table plus corner sequences
// for alu_result_queue at DEPTH=4, DROP_W=8.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_zero, in_cout, in_overflow;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_zero, out_cout, out_overflow;
  logic        out_ready;
  logic [2:0]  count;
  logic        ovf_sticky;
  logic        ovf_clear;
  logic [7:0]  drop_cnt;

  int tests  = 0;
  int failed = 0;

  alu_result_queue #(.DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_result(in_result),
    .in_zero(in_zero), .in_cout(in_cout),
    .in_overflow(in_overflow), .in_ready(in_ready),
    .out_valid(out_valid), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_ready(out_ready),
    .count(count), .ovf_sticky(ovf_sticky),
    .ovf_clear(ovf_clear), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [2:0]  ec;
    logic        ev;
    logic [31:0] eo;
    logic        eir;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d,
                      input logic z, input logic c, input logic o,
                      input logic ordy, input logic clr);
    @(negedge clk);
    in_valid    = iv;
    in_result   = d;
    in_zero     = z;
    in_cout     = c;
    in_overflow = o;
    out_ready   = ordy;
    ovf_clear   = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b1, 32'h5, 1'b0, 3'd1, 1'b1, 32'h5, 1'b1, 8'd0};
    tv[1]  = '{1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, 8'd0};
    tv[2]  = '{1'b1, 32'h1, 1'b0, 3'd1, 1'b1, 32'h1, 1'b1, 8'd0};
    tv[3]  = '{1'b1, 32'h2, 1'b0, 3'd2, 1'b1, 32'h1, 1'b1, 8'd0};
    tv[4]  = '{1'b1, 32'h3, 1'b0, 3'd3, 1'b1, 32'h1, 1'b1, 8'd0};
    tv[5]  = '{1'b1, 32'h4, 1'b0, 3'd4, 1'b1, 32'h1, 1'b0, 8'd0};
    tv[6]  = '{1'b1, 32'h5, 1'b0, 3'd4, 1'b1, 32'h1, 1'b0, 8'd1};
    tv[7]  = '{1'b1, 32'h6, 1'b0, 3'd4, 1'b1, 32'h1, 1'b0, 8'd2};
    tv[8]  = '{1'b1, 32'h7, 1'b1, 3'd3, 1'b1, 32'h2, 1'b1, 8'd3};
    tv[9]  = '{1'b0, 32'h0, 1'b1, 3'd2, 1'b1, 32'h3, 1'b1, 8'd3};
    tv[10] = '{1'b0, 32'h0, 1'b1, 3'd1, 1'b1, 32'h4, 1'b1, 8'd3};
    tv[11] = '{1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, 8'd3};
    tv[12] = '{1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, 8'd3};
    tv[13] = '{1'b1, 32'h8, 1'b1, 3'd1, 1'b1, 32'h8, 1'b1, 8'd3};
    tv[14] = '{1'b1, 32'h9, 1'b1, 3'd1, 1'b1, 32'h9, 1'b1, 8'd3};
    tv[15] = '{1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, 8'd3};

    rst_n = 1'b0;
    in_valid = 0; in_result = 0; in_zero = 0; in_cout = 0;
    in_overflow = 0; out_ready = 0; ovf_clear = 0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tv[i].iv, tv[i].d, 1'b0, 1'b0, 1'b0, tv[i].ordy, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tv[i].ec));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tv[i].eir));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(tv[i].edrop));
      if (tv[i].ev)
        chk($sformatf("vec%0d_result", i), out_result, tv[i].eo);
    end

    // async reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_areset_count", 32'(count), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_drop", 32'(drop_cnt), 32'd0);
    chk("areset_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming: push and pop every cycle, pointers wrap
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d_data", i), out_result, 32'(i));
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stream_drain", 32'(count), 32'd0);
    chk("stream_drop", 32'(drop_cnt), 32'd0);

    // sticky overflow: set beats clear in the same cycle
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    chk("flags_head", {29'd0, out_overflow, out_cout, out_zero}, 32'd7);
    chk("flags_result", out_result, 32'hDEADBEEF);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sticky_clear", 32'(ovf_sticky), 32'd0);
    step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sticky_no_ovf", 32'(ovf_sticky), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // drop counter saturation
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 255; i++)
      step(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_255", 32'(drop_cnt), 32'd255);
    step(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    chk("sat_head", out_result, 32'd0);
    chk("sat_count", 32'(count), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
